alu_sequencer: RTL and testbench

- Control stage that sits beside the dual-read/single-write register RAM.
- Accepts one register-to-register instruction per handshake: op, src0, src1, dst.
- Drives the RAM read addresses, captures both operands and computes an 8-bit ALU result internally.
- Writes the result back through the RAM write port and reports result and flags to the issuer.

---
 rtl/alu_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: control stage beside a dual-read/single-write register RAM.
// Accepts one register-to-register instruction per handshake. It reads both
// operands, computes an ALU result, writes the result back and reports the
// flags to the issuer.
// Optional feature macro: ALU_SEQ_COUNT_EN enables the completed-instruction
// counter on instr_count. Without the macro, instr_count is tied to zero.
module alu_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [2:0]            instr_op,
   input  logic [ADDR_WIDTH-1:0] instr_src0,
   input  logic [ADDR_WIDTH-1:0] instr_src1,
   input  logic [ADDR_WIDTH-1:0] instr_dst,
   output logic [ADDR_WIDTH-1:0] ram_addr0_read,
   output logic [ADDR_WIDTH-1:0] ram_addr1_read,
   input  logic [DATA_WIDTH-1:0] ram_data0_read,
   input  logic [DATA_WIDTH-1:0] ram_data1_read,
   output logic [ADDR_WIDTH-1:0] ram_addr_write,
   output logic [DATA_WIDTH-1:0] ram_data_write,
   output logic                  ram_write_enable,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  carry,
   output logic                  zero,
   output logic [7:0]            instr_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_MOV = 3'b111;

   state_t                state_reg;
   logic [2:0]            op_reg;
   logic [ADDR_WIDTH-1:0] src0_reg;
   logic [ADDR_WIDTH-1:0] src1_reg;
   logic [ADDR_WIDTH-1:0] dst_reg;
   logic [DATA_WIDTH-1:0] operand0_reg;
   logic [DATA_WIDTH-1:0] operand1_reg;
   logic [DATA_WIDTH-1:0] result_reg;
   logic                  carry_reg;
   logic                  zero_reg;

   // Bit DATA_WIDTH carries the carry/borrow; the lower bits are the result.
   logic [DATA_WIDTH:0]   alu_next;

   // ALU on the captured operands; the result is only registered in EXEC.
   always_comb begin
      alu_next = '0;
      case (op_reg)
         OP_ADD:  alu_next = {1'b0, operand0_reg} + {1'b0, operand1_reg};
         // The 9-bit difference sets its top bit exactly when a < b (borrow).
         OP_SUB:  alu_next = {1'b0, operand0_reg} - {1'b0, operand1_reg};
         OP_AND:  alu_next = {1'b0, operand0_reg & operand1_reg};
         OP_OR:   alu_next = {1'b0, operand0_reg | operand1_reg};
         OP_XOR:  alu_next = {1'b0, operand0_reg ^ operand1_reg};
         OP_NOT:  alu_next = {1'b0, ~operand0_reg};
         OP_SHL:  alu_next = {operand0_reg, 1'b0};
         OP_MOV:  alu_next = {1'b0, operand0_reg};
         default: alu_next = '0;
      endcase
   end

   // Sequencer FSM with the instruction latch, operand capture and flag registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         op_reg       <= '0;
         src0_reg     <= '0;
         src1_reg     <= '0;
         dst_reg      <= '0;
         operand0_reg <= '0;
         operand1_reg <= '0;
         result_reg   <= '0;
         carry_reg    <= 1'b0;
         zero_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (instr_valid) begin
                  op_reg    <= instr_op;
                  src0_reg  <= instr_src0;
                  src1_reg  <= instr_src1;
                  dst_reg   <= instr_dst;
                  state_reg <= READ;
               end
            end
            READ: begin
               operand0_reg <= ram_data0_read;
               operand1_reg <= ram_data1_read;
               state_reg    <= EXEC;
            end
            EXEC: begin
               result_reg <= alu_next[DATA_WIDTH-1:0];
               carry_reg  <= alu_next[DATA_WIDTH];
               zero_reg   <= (alu_next[DATA_WIDTH-1:0] == '0);
               state_reg  <= WRITE;
            end
            WRITE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Reset gates the write strobe combinationally so a reset landing in WRITE
   // suppresses the RAM commit at that same edge.
   assign instr_ready      = (state_reg == IDLE);
   assign ram_write_enable = (state_reg == WRITE) & ~reset;
   assign done             = (state_reg == WRITE) & ~reset;
   assign ram_addr0_read   = src0_reg;
   assign ram_addr1_read   = src1_reg;
   assign ram_addr_write   = dst_reg;
   assign ram_data_write   = result_reg;
   assign result           = result_reg;
   assign carry            = carry_reg;
   assign zero             = zero_reg;

`ifdef ALU_SEQ_COUNT_EN
   logic [7:0] count_reg;

   // Count every completed writeback; wraps naturally at 8 bits.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg <= '0;
      end else if (done) begin
         count_reg <= count_reg + 8'd1;
      end
   end

   assign instr_count = count_reg;
`else
   assign instr_count = 8'd0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural 16x8 register RAM.
// Build with ALU_SEQ_COUNT_EN defined to exercise the instruction counter.
module tb_alu_sequencer;

   logic       clock;
   logic       reset;
   logic       instr_valid;
   logic       instr_ready;
   logic [2:0] instr_op;
   logic [3:0] instr_src0;
   logic [3:0] instr_src1;
   logic [3:0] instr_dst;
   logic [3:0] ram_addr0_read;
   logic [3:0] ram_addr1_read;
   logic [7:0] ram_data0_read;
   logic [7:0] ram_data1_read;
   logic [3:0] ram_addr_write;
   logic [7:0] ram_data_write;
   logic       ram_write_enable;
   logic       done;
   logic [7:0] result;
   logic       carry;
   logic       zero;
   logic [7:0] instr_count;

   int         checks;
   int         errors;
   logic [7:0] exp_count;

   // Bench-side RAM preload port
   logic       poke_en;
   logic [3:0] poke_addr;
   logic [7:0] poke_data;
   logic [7:0] mem [16];

   alu_sequencer dut (
      .clock            (clock),
      .reset            (reset),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instr_op         (instr_op),
      .instr_src0       (instr_src0),
      .instr_src1       (instr_src1),
      .instr_dst        (instr_dst),
      .ram_addr0_read   (ram_addr0_read),
      .ram_addr1_read   (ram_addr1_read),
      .ram_data0_read   (ram_data0_read),
      .ram_data1_read   (ram_data1_read),
      .ram_addr_write   (ram_addr_write),
      .ram_data_write   (ram_data_write),
      .ram_write_enable (ram_write_enable),
      .done             (done),
      .result           (result),
      .carry            (carry),
      .zero             (zero),
      .instr_count      (instr_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Register RAM: combinational reads, write on the rising edge.
   assign ram_data0_read = mem[ram_addr0_read];
   assign ram_data1_read = mem[ram_addr1_read];
   always @(posedge clock) begin
      if (poke_en) mem[poke_addr] <= poke_data;
      else if (ram_write_enable) mem[ram_addr_write] <= ram_data_write;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [3:0] a, input logic [7:0] d);
      @(negedge clock);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(negedge clock);
      poke_en = 1'b0;
   endtask

   // Steps after the accept edge: READ, EXEC, WRITE, then back in IDLE.
   task automatic finish_instr(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] d,
                               input logic [7:0] er, input logic ec, input logic ez);
      @(negedge clock);                         // READ
      check("read_ready", instr_ready, 0);
      check("read_done", done, 0);
      check("read_addr0", ram_addr0_read, s0);
      check("read_addr1", ram_addr1_read, s1);
      @(negedge clock);                         // EXEC
      check("exec_ready", instr_ready, 0);
      check("exec_we", ram_write_enable, 0);
      @(negedge clock);                         // WRITE
      check("write_done", done, 1);
      check("write_we", ram_write_enable, 1);
      check("write_addr", ram_addr_write, d);
      check("write_data", ram_data_write, er);
      check("result", result, er);
      check("carry", carry, ec);
      check("zero", zero, ez);
`ifdef ALU_SEQ_COUNT_EN
      exp_count = exp_count + 8'd1;
`endif
      @(negedge clock);                         // IDLE
      check("idle_ready", instr_ready, 1);
      check("idle_done", done, 0);
      check("ram_commit", mem[d], er);
      check("instr_count", instr_count, exp_count);
      $display("txn src0=%0d src1=%0d dst=%0d result=%02h carry=%0b zero=%0b count=%0d",
               s0, s1, d, result, carry, zero, instr_count);
   endtask

   task automatic run_instr(input logic [2:0] op, input logic [3:0] s0, input logic [3:0] s1,
                            input logic [3:0] d, input logic [7:0] er, input logic ec, input logic ez);
      int waitc;
      instr_valid = 1'b1; instr_op = op; instr_src0 = s0; instr_src1 = s1; instr_dst = d;
      waitc = 0;
      while (!instr_ready && waitc < 20) begin
         @(negedge clock);
         waitc++;
      end
      check("accept_ready", instr_ready, 1);
      @(posedge clock);
      #1;
      // Scramble the fields: they must be ignored outside the handshake.
      instr_valid = 1'b0; instr_op = ~op; instr_src0 = ~s0; instr_src1 = ~s1; instr_dst = ~d;
      finish_instr(s0, s1, d, er, ec, ez);
   endtask

   initial begin
      int k;
      checks = 0; errors = 0; exp_count = 8'd0;
      reset = 1'b1; instr_valid = 1'b0; instr_op = '0;
      instr_src0 = '0; instr_src1 = '0; instr_dst = '0;
      poke_en = 1'b0; poke_addr = '0; poke_data = '0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;

      // Reset held for two cycles
      @(negedge clock);
      check("rst_we_c1", ram_write_enable, 0);
      @(negedge clock);
      check("rst_we_c2", ram_write_enable, 0);
      reset = 1'b0;
      check("rst_ready", instr_ready, 1);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_carry", carry, 0);
      check("rst_zero", zero, 0);
      check("rst_addr0", ram_addr0_read, 0);
      check("rst_addr1", ram_addr1_read, 0);
      check("rst_waddr", ram_addr_write, 0);
      check("rst_wdata", ram_data_write, 0);
      check("rst_count", instr_count, 0);

      poke(4'd1, 8'h7F); poke(4'd2, 8'h01);
      poke(4'd4, 8'hFF); poke(4'd5, 8'h01);
      poke(4'd7, 8'h05); poke(4'd8, 8'h07);
      poke(4'd11, 8'h55);

      run_instr(3'b000, 4'd1, 4'd2, 4'd3, 8'h80, 1'b0, 1'b0);   // ADD 7F+01
      run_instr(3'b000, 4'd4, 4'd5, 4'd6, 8'h00, 1'b1, 1'b1);   // ADD FF+01
      run_instr(3'b001, 4'd7, 4'd8, 4'd13, 8'hFE, 1'b1, 1'b0);  // SUB 05-07
      run_instr(3'b010, 4'd1, 4'd3, 4'd14, 8'h00, 1'b0, 1'b1);  // AND 7F&80
      run_instr(3'b011, 4'd1, 4'd3, 4'd14, 8'hFF, 1'b0, 1'b0);  // OR  7F|80
      run_instr(3'b100, 4'd1, 4'd1, 4'd15, 8'h00, 1'b0, 1'b1);  // XOR same reg
      run_instr(3'b101, 4'd2, 4'd0, 4'd15, 8'hFE, 1'b0, 1'b0);  // NOT 01
      run_instr(3'b110, 4'd3, 4'd0, 4'd3, 8'h00, 1'b1, 1'b1);   // SHL 80, src==dst

      // Back-to-back with instr_valid held high
      @(negedge clock);
      instr_valid = 1'b1; instr_op = 3'b111; instr_src0 = 4'd1; instr_src1 = 4'd0; instr_dst = 4'd9;
      check("b2b_ready1", instr_ready, 1);
      @(posedge clock);
      @(negedge clock);
      k = 1;
      instr_op = 3'b110; instr_src0 = 4'd9; instr_src1 = 4'd0; instr_dst = 4'd10;
      while (!instr_ready && k < 10) begin
         @(negedge clock);
         k++;
      end
      check("b2b_spacing", k, 4);
      check("b2b_mov_commit", mem[9], 8'h7F);
`ifdef ALU_SEQ_COUNT_EN
      exp_count = exp_count + 8'd1;
`endif
      check("b2b_mov_count", instr_count, exp_count);
      $display("txn MOV src0=1 dst=9 result=%02h", mem[9]);
      @(posedge clock);
      #1;
      instr_valid = 1'b0;
      finish_instr(4'd9, 4'd0, 4'd10, 8'hFE, 1'b0, 1'b0);

      // Reset pulsed during WRITE
      @(negedge clock);
      instr_valid = 1'b1; instr_op = 3'b000; instr_src0 = 4'd1; instr_src1 = 4'd2; instr_dst = 4'd11;
      @(posedge clock);
      #1;
      instr_valid = 1'b0;
      @(negedge clock);                         // READ
      @(negedge clock);                         // EXEC
      @(negedge clock);                         // WRITE
      check("abort_done_before", done, 1);
      reset = 1'b1;
      #1;
      check("abort_done", done, 0);
      check("abort_we", ram_write_enable, 0);
      @(negedge clock);
      reset = 1'b0;
      exp_count = 8'd0;
      check("abort_ready", instr_ready, 1);
      check("abort_ram", mem[11], 8'h55);
      check("abort_result", result, 0);
      check("abort_count", instr_count, 0);
      $display("txn ADD dst=11 aborted ram11=%02h", mem[11]);

`ifdef ALU_SEQ_COUNT_EN
      // 257 writebacks wrap the counter to 1
      for (int i = 0; i < 257; i++) begin
         run_instr(3'b111, 4'd1, 4'd0, 4'd12, 8'h7F, 1'b0, 1'b0);
      end
      check("count_wrap", instr_count, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so a stuck DUT still reaches a verdict
   initial begin
      #2000000;
      $display("FAIL timeout simulation limit reached");
      $fatal(1, "timeout");
   end

endmodule
